// File: rtl/instr_queue_decode.sv
// DEPTH-entry instruction FIFO with built-in field decode of the head entry.
// Define IR_SIGN_EXT_EN to sign-extend immediate_value; zero-extension otherwise.
module instr_queue_decode #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned OP_BITS  = 4,
   parameter int unsigned REG_BITS = 4,
   parameter int unsigned IMM_BITS = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_instr,
   output logic                         in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OP_BITS-1:0]           op_code,
   output logic [REG_BITS-1:0]          A_index_out,
   output logic [OP_BITS-1:0]           ext_op_code,
   output logic [WIDTH-1:0]             immediate_value,
   output logic [REG_BITS-1:0]          B_index_out,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;

   logic                w_push;
   logic                w_pop;
   logic [WIDTH-1:0]    w_head;
   logic [IMM_BITS-1:0] w_imm_raw;
   logic [WIDTH-1:0]    w_imm_ext;

   // in_ready never looks at out_ready: a full queue refuses a push even on a pop cycle
   assign in_ready  = (r_count != CW'(DEPTH)) & ~flush & reset_n;
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign count     = r_count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_instr;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head    = r_mem[r_rd_ptr];
   assign w_imm_raw = w_head[IMM_BITS-1:0];

`ifdef IR_SIGN_EXT_EN
   assign w_imm_ext = {{(WIDTH-IMM_BITS){w_imm_raw[IMM_BITS-1]}}, w_imm_raw};
`else
   assign w_imm_ext = {{(WIDTH-IMM_BITS){1'b0}}, w_imm_raw};
`endif

   // decode fields are masked to zero whenever the head slot holds no valid word
   assign op_code         = out_valid ? w_head[WIDTH-1 -: OP_BITS]                 : '0;
   assign A_index_out     = out_valid ? w_head[WIDTH-OP_BITS-1 -: REG_BITS]        : '0;
   assign ext_op_code     = out_valid ? w_head[IMM_BITS-1 -: OP_BITS]              : '0;
   assign immediate_value = out_valid ? w_imm_ext                                  : '0;
   assign B_index_out     = out_valid ? w_head[REG_BITS-1:0]                       : '0;

endmodule

// File: tb/tb_instr_queue_decode.sv
// Self-checking bench for instr_queue_decode: queue-based reference model plus directed vectors.
module tb_instr_queue_decode;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              flush;
   logic              in_valid;
   logic [WIDTH-1:0]  in_instr;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        op_code;
   logic [3:0]        A_index_out;
   logic [3:0]        ext_op_code;
   logic [WIDTH-1:0]  immediate_value;
   logic [3:0]        B_index_out;
   logic [2:0]        count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [15:0] model_q [$];
   bit          model_live = 1'b0;

   instr_queue_decode #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .OP_BITS  (4),
      .REG_BITS (4),
      .IMM_BITS (8)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_instr        (in_instr),
      .in_ready        (in_ready),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .op_code         (op_code),
      .A_index_out     (A_index_out),
      .ext_op_code     (ext_op_code),
      .immediate_value (immediate_value),
      .B_index_out     (B_index_out),
      .count           (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] imm_of(input logic [15:0] h);
      logic [15:0] v;
      v = h & 16'h00FF;
`ifdef IR_SIGN_EXT_EN
      if ((h & 16'h0080) != 0) v = v | 16'hFF00;
`endif
      return v;
   endfunction

   // Reference model: an unbounded queue capped at DEPTH by the acceptance rule
   always @(posedge clk) begin
      bit acc, take;
      acc  = in_valid && (model_q.size() != DEPTH) && !flush && reset_n;
      take = (model_q.size() != 0) && out_ready;
      if (!reset_n || flush) begin
         model_q.delete();
      end else begin
         if (take) void'(model_q.pop_front());
         if (acc)  model_q.push_back(in_instr);
      end
      if (!reset_n) model_live = 1'b1;
   end

   always @(negedge clk) begin
      if (model_live) begin
         logic [15:0] h;
         bit          v;
         v = model_q.size() != 0;
         h = v ? model_q[0] : 16'h0000;
         chk("in_ready",  32'(in_ready),  32'((model_q.size() != DEPTH) && !flush && reset_n));
         chk("out_valid", 32'(out_valid), 32'(v));
         chk("count",     32'(count),     32'(model_q.size()));
         chk("op_code",   32'(op_code),     v ? 32'(h / 16'h1000)        : 0);
         chk("A_index",   32'(A_index_out), v ? 32'((h / 16'h0100) % 16) : 0);
         chk("ext_op",    32'(ext_op_code), v ? 32'((h / 16'h0010) % 16) : 0);
         chk("imm",       32'(immediate_value), v ? 32'(imm_of(h))      : 0);
         chk("B_index",   32'(B_index_out), v ? 32'(h % 16)              : 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n  = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_count",     32'(count),     0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready",  32'(in_ready),  0);
      reset_n = 1'b1;
      #1;
      chk("rel_in_ready",  32'(in_ready),  1);

      // decode of 0x3A5C
      in_valid = 1'b1; in_instr = 16'h3A5C;
      tick();
      in_valid = 1'b0;
      chk("dec_valid", 32'(out_valid), 1);
      chk("dec_op",    32'(op_code), 32'h3);
      chk("dec_A",     32'(A_index_out), 32'hA);
      chk("dec_ext",   32'(ext_op_code), 32'h5);
      chk("dec_imm",   32'(immediate_value), 32'h005C);
      chk("dec_B",     32'(B_index_out), 32'hC);
      chk("dec_count", 32'(count), 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pop_count", 32'(count), 0);

      // immediate extension
      in_valid = 1'b1; in_instr = 16'h1F80;
      tick();
      in_valid = 1'b0;
`ifdef IR_SIGN_EXT_EN
      chk("ext_imm", 32'(immediate_value), 32'hFF80);
`else
      chk("ext_imm", 32'(immediate_value), 32'h0080);
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // fill and stall: 0x5555 must be refused
      for (int k = 1; k <= 5; k++) begin
         in_valid = 1'b1;
         in_instr = 16'(k * 16'h1111);
         tick();
      end
      chk("full_count",    32'(count), 4);
      chk("full_in_ready", 32'(in_ready), 0);
      chk("full_head_op",  32'(op_code), 1);
      chk("full_head_imm", 32'(immediate_value), 32'h0011);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      out_ready = 1'b0;
      chk("drained_count", 32'(count), 0);

      // concurrent push/pop across pointer wrap
      in_valid = 1'b1;
      in_instr = 16'hA001; tick();
      in_instr = 16'hB002; tick();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_instr = 16'h5E00 | 16'(k);
         tick();
         chk("stream_count", 32'(count), 2);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("stream_head_op", 32'(op_code), 5);
      chk("stream_head_B",  32'(B_index_out), 6);

      // flush at count 3 with simultaneous handshakes
      in_valid = 1'b1; in_instr = 16'h7123;
      tick();
      chk("pre_flush_count", 32'(count), 3);
      flush = 1'b1; in_instr = 16'h6ABC; out_ready = 1'b1;
      #1;
      chk("flush_in_ready", 32'(in_ready), 0);
      tick();
      chk("flush_count", 32'(count), 0);
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_op",    32'(op_code), 0);
      chk("flush_imm",   32'(immediate_value), 0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick();

      // reset mid-operation at count 2
      in_valid = 1'b1;
      in_instr = 16'h9876; tick();
      in_instr = 16'hFEDC; tick();
      in_valid = 1'b0;
      chk("pre_rst_count", 32'(count), 2);
      reset_n = 1'b0;
      tick();
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_B",     32'(B_index_out), 0);
      reset_n = 1'b1;
      #1;
      chk("mid_rel_in_ready", 32'(in_ready), 1);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
